// File: rtl/uart_rx_os16.sv
// 16x-oversampling 8N1 UART receiver driven by an external oversample strobe.
// Start is qualified at mid-bit; data bits and the stop bit are sampled at mid-bit.
module uart_rx_os16 #(
  parameter int DATA_BITS = 8,
  parameter int OS_RATE   = 16
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic                 rxclk_en,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int              SW     = $clog2(OS_RATE);
  localparam logic [SW-1:0]   S_HALF = SW'(OS_RATE/2 - 1);
  localparam logic [SW-1:0]   S_LAST = SW'(OS_RATE - 1);
  localparam logic [2:0]      B_LAST = 3'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state, state_nx;
  logic                   rx_s1, rx_s2;
  logic [SW-1:0]          sample, sample_nx;
  logic [2:0]             bitpos, bitpos_nx;
  logic [DATA_BITS-1:0]   shreg, shreg_nx;
  logic                   byte_ok, byte_bad;

  always_ff @(posedge clk_50m) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    sample_nx = sample;
    bitpos_nx = bitpos;
    shreg_nx  = shreg;
    byte_ok   = 1'b0;
    byte_bad  = 1'b0;
    if (rxclk_en) begin
      case (state)
        IDLE: begin
          if (!rx_s2) begin
            state_nx  = START;
            sample_nx = '0;
          end
        end
        START: begin
          sample_nx = sample + 1'b1;
          // Line still low at mid start bit: real start, else a glitch.
          if (sample == S_HALF) begin
            sample_nx = '0;
            bitpos_nx = '0;
            state_nx  = rx_s2 ? IDLE : DATA;
          end
        end
        DATA: begin
          sample_nx = sample + 1'b1;
          if (sample == S_LAST) begin
            shreg_nx[bitpos] = rx_s2;
            bitpos_nx        = bitpos + 1'b1;
            if (bitpos == B_LAST) state_nx = STOP;
          end
        end
        STOP: begin
          sample_nx = sample + 1'b1;
          // Leave at mid stop bit so a back-to-back start edge is not missed.
          if (sample == S_LAST) begin
            state_nx = IDLE;
            byte_ok  = rx_s2;
            byte_bad = !rx_s2;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      sample    <= '0;
      bitpos    <= '0;
      shreg     <= '0;
      data      <= '0;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_s1  <= rx;
      rx_s2  <= rx_s1;
      sample <= sample_nx;
      bitpos <= bitpos_nx;
      shreg  <= shreg_nx;
      if (byte_ok) data <= shreg;
      // A set event in the same cycle as rdy_clr wins.
      rdy       <= byte_ok | (rdy & ~rdy_clr);
      overrun   <= (byte_ok & rdy) | (overrun & ~rdy_clr);
      frame_err <= byte_bad | (frame_err & ~rdy_clr);
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: strobe every 4 clocks (64-clock bit), scoreboard of
// expected bytes popped whenever the receiver publishes a new byte.
module tb_uart_rx_os16;

  logic       clk_50m = 1'b0;
  logic       rst     = 1'b1;
  logic       rx      = 1'b1;
  logic       rdy_clr = 1'b0;
  logic       rxclk_en;
  logic [7:0] data;
  logic       rdy, frame_err, overrun;

  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_b;
  int unsigned start_cyc = 0;
  int unsigned rise_cyc  = 0;
  int unsigned lat       = 0;

  logic       rst_q = 1'b1;
  logic       rdy_q = 1'b0;
  logic       ov_q  = 1'b0;
  logic [7:0] data_q = 8'h00;

  uart_rx_os16 dut (
    .clk_50m  (clk_50m),
    .rst      (rst),
    .rxclk_en (rxclk_en),
    .rx       (rx),
    .rdy_clr  (rdy_clr),
    .data     (data),
    .rdy      (rdy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk_50m = ~clk_50m;
  always @(posedge clk_50m) cyc <= cyc + 1;
  assign rxclk_en = (cyc[1:0] == 2'd3);

  task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk_50m);
    #1;
  endtask

  // Scoreboard: a new byte is visible when data changes, rdy rises or overrun rises.
  always @(negedge clk_50m) begin
    if (!rst && !rst_q) begin
      if (rdy && !rdy_q) rise_cyc <= cyc;
      if ((rdy && !rdy_q) || (data != data_q) || (overrun && !ov_q)) begin
        if (exp_q.size() == 0) chk("spurious_byte", data, 32'hFFFF_FFFF);
        else begin
          exp_b = exp_q.pop_front();
          chk("data", data, exp_b);
        end
      end
    end
    rst_q  <= rst;
    rdy_q  <= rdy;
    ov_q   <= overrun;
    data_q <= data;
  end

  task automatic align4();
    while (cyc[1:0] != 2'd0) wait_clk(1);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    align4();
    start_cyc = cyc;
    if (stop) exp_q.push_back(b);
    rx = 1'b0;
    wait_clk(64);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clk(64);
    end
    rx = stop;
    wait_clk(64);
    rx = 1'b1;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      wait_clk(1);
      k++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic pulse_clr();
    rdy_clr = 1'b1;
    wait_clk(1);
    rdy_clr = 1'b0;
  endtask

  initial begin
    wait_clk(5);
    chk("rst_data", data, 8'h00);
    chk("rst_rdy", rdy, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    rst = 1'b0;
    wait_clk(20);

    // single byte + latency
    send_frame(8'hA5, 1'b1);
    drain("a5_drain");
    lat = rise_cyc - start_cyc;
    chk("a5_latency", (lat >= 600 && lat <= 620), 1);
    chk("a5_rdy", rdy, 1);
    chk("a5_ferr", frame_err, 0);
    chk("a5_ovr", overrun, 0);
    pulse_clr();
    chk("a5_clr_rdy", rdy, 0);

    // glitch rejection
    wait_clk(10);
    rx = 1'b0;
    wait_clk(16);
    rx = 1'b1;
    wait_clk(100);
    chk("gl_rdy", rdy, 0);
    chk("gl_ferr", frame_err, 0);
    chk("gl_ovr", overrun, 0);
    send_frame(8'h3C, 1'b1);
    drain("3c_drain");
    chk("3c_rdy", rdy, 1);
    pulse_clr();

    // framing error
    wait_clk(20);
    send_frame(8'h55, 1'b0);
    wait_clk(80);
    chk("fe_ferr", frame_err, 1);
    chk("fe_rdy", rdy, 0);
    chk("fe_data_kept", data, 8'h3C);
    pulse_clr();
    chk("fe_clr", frame_err, 0);

    // back-to-back with overrun
    wait_clk(20);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    drain("b2b_drain");
    chk("b2b_data", data, 8'hFF);
    chk("b2b_rdy", rdy, 1);
    chk("b2b_ovr", overrun, 1);
    chk("b2b_ferr", frame_err, 0);
    pulse_clr();
    chk("b2b_clr_ovr", overrun, 0);

    // set/clear collision: rdy_clr held across the edge that sets rdy
    wait_clk(20);
    fork
      send_frame(8'h81, 1'b1);
      begin
        int unsigned s;
        align4();
        s = cyc;
        while (cyc != s + lat - 1) wait_clk(1);
        rdy_clr = 1'b1;
        wait_clk(1);
        rdy_clr = 1'b0;
      end
    join
    drain("col_drain");
    chk("col_rdy", rdy, 1);

    // mid-frame reset during bit 4 of 0xC3
    wait_clk(20);
    align4();
    rx = 1'b0;
    wait_clk(64);
    for (int i = 0; i < 4; i++) begin
      rx = (8'hC3 >> i) & 1;
      wait_clk(64);
    end
    rx = 1'b0;
    wait_clk(32);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    rx  = 1'b1;
    wait_clk(700);
    chk("mr_data", data, 8'h00);
    chk("mr_rdy", rdy, 0);
    chk("mr_ferr", frame_err, 0);
    chk("mr_ovr", overrun, 0);
    send_frame(8'h12, 1'b1);
    drain("12_drain");
    chk("12_rdy", rdy, 1);
    chk("12_ovr", overrun, 0);

    wait_clk(20);
    chk("q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/uart_rx_os16.md
# uart_rx_os16

16x-oversampling UART receiver, 8N1, LSB first, that consumes the `rxclk_en` strobe from the baud generator. It synchronizes the asynchronous `rx` line, detects and qualifies the start bit, samples each data bit at mid-bit, and checks the stop bit. It presents the received byte with a ready flag, plus framing-error and overrun indications, to the host logic on the 50 MHz domain.

## Interface
Parameters:
- `DATA_BITS`, 8: data bits per frame. Only the value 8 is supported and verified.
- `OS_RATE`, 16: `rxclk_en` ticks per bit. Must be a power of two of at least 4.

Ports:
- `clk_50m`, in, 1: system clock. All logic is on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `rxclk_en`, in, 1: oversample strobe. It is a one-cycle pulse at 16x baud.
- `rx`, in, 1: asynchronous serial input. The line idles high.
- `rdy_clr`, in, 1: host acknowledge. It clears `rdy`, `frame_err` and `overrun`.
- `data`, out, 8: last good byte received. It holds its value until the next good byte.
- `rdy`, out, 1: a byte is available. It is sticky until `rdy_clr`.
- `frame_err`, out, 1: a stop bit was sampled low. It is sticky until `rdy_clr`.
- `overrun`, out, 1: a good byte completed while `rdy` was already 1. It is sticky until `rdy_clr`.

## Operation
- **Input synchronizer:** two flops, `rx` → `rx_s1` → `rx_s2`. Both flops reset to 1. All decisions use `rx_s2`.
- **Counters:**
  - Sample counter `sample`, log2(OS_RATE) bits. It advances only on cycles where `rxclk_en`=1 and wraps modulo OS_RATE.
  - Bit counter `bitpos`, 3 bits.
- **FSM states:** IDLE, START, DATA, STOP. Transitions happen only on `rxclk_en` cycles.
  - **IDLE:**
    - If `rx_s2`=0, go to START with `sample`=0.
    - Otherwise, stay in IDLE.
  - **START:**
    - Increment `sample` on each tick.
    - When `sample`=OS_RATE/2−1 (7) and `rx_s2`=0, the start bit is confirmed. Go to DATA with `sample`=0 and `bitpos`=0.
    - When `sample`=7 and `rx_s2`=1, treat it as a glitch. Return to IDLE with no flag set.
  - **DATA:**
    - Increment `sample` on each tick.
    - At `sample`=OS_RATE−1 (mid-bit), load `rx_s2` into shift register bit [`bitpos`] (LSB first) and increment `bitpos`.
    - When the mid-bit sample of `bitpos`=7 is taken, go to STOP with `sample`=0.
  - **STOP:**
    - At `sample`=15 with `rx_s2`=1:
      - Copy the shift register to `data`.
      - Set `rdy`.
      - If `rdy` was already 1, set `overrun`; the new byte overwrites `data`.
    - At `sample`=15 with `rx_s2`=0: set `frame_err`. `data` and `rdy` are unchanged.
    - In either case, go to IDLE. Exit happens at mid-stop-bit, so a back-to-back start bit is caught.
- **Flag clear:** `rdy_clr`=1 clears `rdy`, `frame_err` and `overrun` on the next edge, in any state and regardless of `rxclk_en`.
  - If a set event and `rdy_clr` occur in the same cycle, the set wins: the flag is 1 after the edge.
- **Reset:**
  - Applies from any state, including mid-frame.
  - Forces IDLE, `sample`=0, `bitpos`=0, shift register=0, `data`=0, `rdy`=0, `frame_err`=0, `overrun`=0, synchronizer flops=1.
  - A partially received frame is discarded. If `rx` is still low after reset releases, it is treated as a new start bit.

## Timing
- `rxclk_en` period is P clocks. From the baud generator, P=28, which gives a bit time of 16·P = 448 clocks.
- Synchronizer latency is 2 clocks.
- Start confirmation comes 8 ticks after the first low `rx_s2` sample.
- Each data bit is sampled 16 ticks after the previous sample.
- `rdy`, `data` and `frame_err` update on the clock edge following the `rxclk_en` cycle that holds the stop-bit mid sample. That is 8+8·16+16 = 152 ticks after start detection.
- `rxclk_en` is ignored except as an enable. No output toggles on cycles without `rxclk_en`, except for clears caused by `rdy_clr`.
- Tolerance: data is sampled within ±1 tick plus 2 clocks of true mid-bit. Baud mismatch up to ±3% must still decode correctly.

## Test plan
All tests use a bench strobe with P=4, so one bit is 64 clocks.
- **Single byte:** reset, then send 0xA5 (start, 1,0,1,0,0,1,0,1 LSB first, stop) → `data`=0xA5 and `rdy`=1 about 608 clocks after the start edge. `frame_err`=0 and `overrun`=0. Pulsing `rdy_clr` → `rdy`=0 next cycle.
- **Glitch rejection:** `rx` low for 16 clocks, then high → FSM back in IDLE, `rdy`=0, all flags 0. Then send 0x3C → `data`=0x3C.
- **Framing error:** send 0x55 with the stop bit held low → `frame_err`=1, `rdy`=0, `data` keeps its prior value. Then `rdy_clr` → `frame_err`=0.
- **Back-to-back with overrun:** send 0x00 then 0xFF with no idle gap and no `rdy_clr` → `data`=0xFF, `rdy`=1, `overrun`=1, `frame_err`=0.
- **Set/clear collision:** assert `rdy_clr` in the exact cycle that `rdy` is set by byte 0x81 → `rdy`=1 after the edge.
- **Mid-frame reset:** assert `rst` for 1 clock during bit 4 of 0xC3, keep `rx` high afterward → all outputs 0 and no `rdy`. The next frame 0x12 decodes correctly.
